// File: rtl/sram_ecc_par.sv
`default_nettype none
// ============================================================================
// Module   : sram_ecc_par
// Purpose  : Single-port SRAM with one even-parity bit per byte lane. Every
//            read is checked and per-lane errors are reported with the beat.
//            A sticky error log records the first failing address and a
//            saturating count. After reset, a zero-fill sweep initialises the
//            whole array.
// Ports    : clk_i/rst_i         clock, synchronous active-high reset
//            req_i/gnt_o         request / accepted (ready, not in reset)
//            we_i, addr_i        write select, word address
//            wdata_i, be_i       write data, byte enables
//            inj_i               invert stored parity of enabled lanes
//            rdata_o, rvalid_o   read data (held), single-cycle beat strobe
//            rerr_o, rerr_be_o   any / per-lane parity mismatch on the beat
//            err_sticky_o, err_addr_o, err_cnt_o, err_clr_i   error log
//            init_done_o         zero-fill sweep finished
// Revision : 1.0 - initial release
// ============================================================================
module sram_ecc_par #(
  parameter int DATA_WIDTH    = 64,
  parameter int NUM_WORDS     = 1024,
  parameter int OUT_REGS      = 0,
  parameter int ERR_CNT_WIDTH = 8,
  parameter int INIT_ON_RESET = 1,
  localparam int AW = $clog2(NUM_WORDS),
  localparam int NB = (DATA_WIDTH + 7) / 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     req_i,
  output logic                     gnt_o,
  input  logic                     we_i,
  input  logic [AW-1:0]            addr_i,
  input  logic [DATA_WIDTH-1:0]    wdata_i,
  input  logic [NB-1:0]            be_i,
  input  logic [NB-1:0]            inj_i,
  output logic [DATA_WIDTH-1:0]    rdata_o,
  output logic                     rvalid_o,
  output logic                     rerr_o,
  output logic [NB-1:0]            rerr_be_o,
  output logic                     err_sticky_o,
  output logic [AW-1:0]            err_addr_o,
  output logic [ERR_CNT_WIDTH-1:0] err_cnt_o,
  input  logic                     err_clr_i,
  output logic                     init_done_o
);

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [AW-1:0] r_init_ptr, w_init_ptr_nxt;

  logic                  w_init_we;
  logic                  w_acc, w_wr, w_rd;
  logic [AW-1:0]         w_waddr;
  logic [DATA_WIDTH-1:0] w_q;
  logic [NB-1:0]         w_perr;

  logic                  r_v1;
  logic [AW-1:0]         r_addr1;

  // Beat as seen at the outputs (after the optional output register).
  logic                  w_bv;
  logic [DATA_WIDTH-1:0] w_bd;
  logic [NB-1:0]         w_bbe;
  logic [AW-1:0]         w_baddr;

  logic                     r_err_sticky;
  logic [AW-1:0]            r_err_addr;
  logic [ERR_CNT_WIDTH-1:0] r_err_cnt;

  // --------------------------------------------------------------------------
  // Init / ready control
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= (INIT_ON_RESET != 0) ? ST_INIT : ST_READY;
      r_init_ptr <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_init_ptr <= w_init_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_init_ptr_nxt = r_init_ptr;
    if (r_state == ST_INIT) begin
      w_init_ptr_nxt = r_init_ptr + AW'(1);
      if (r_init_ptr == AW'(NUM_WORDS - 1)) begin
        w_state_nxt = ST_READY;
      end
    end
  end

  assign w_init_we   = (r_state == ST_INIT) & ~rst_i;
  assign gnt_o       = (r_state == ST_READY) & ~rst_i;
  assign init_done_o = (r_state == ST_READY);

  assign w_acc   = req_i & gnt_o;
  assign w_wr    = w_acc & we_i;
  assign w_rd    = w_acc & ~we_i;
  assign w_waddr = w_init_we ? r_init_ptr : addr_i;

  // --------------------------------------------------------------------------
  // Per-lane storage: each lane owns its data and parity array so partial
  // writes touch only the enabled lanes. The top lane may be narrower than 8.
  // --------------------------------------------------------------------------
  for (genvar b = 0; b < NB; b++) begin : g_lane
    localparam int LO = 8 * b;
    localparam int LW = ((DATA_WIDTH - LO) >= 8) ? 8 : (DATA_WIDTH - LO);

    logic [LW-1:0] r_mem [NUM_WORDS];
    logic          r_par [NUM_WORDS];
    logic [LW-1:0] r_q;
    logic          r_qp;
    logic          w_we;
    logic [LW-1:0] w_wd;
    logic          w_wp;

    assign w_we = w_init_we | (w_wr & be_i[b]);
    assign w_wd = w_init_we ? '0 : wdata_i[LO +: LW];
    assign w_wp = w_init_we ? 1'b0 : ((^wdata_i[LO +: LW]) ^ inj_i[b]);

    always_ff @(posedge clk_i) begin
      if (w_we) begin
        r_mem[w_waddr] <= w_wd;
        r_par[w_waddr] <= w_wp;
      end
    end

    // Read registers hold between reads so rdata_o keeps its last value.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_q  <= '0;
        r_qp <= 1'b0;
      end else if (w_rd) begin
        r_q  <= r_mem[addr_i];
        r_qp <= r_par[addr_i];
      end
    end

    assign w_q[LO +: LW] = r_q;
    // Masked by the beat strobe so stale held data never flags an error.
    assign w_perr[b]     = r_v1 & ((^r_q) ^ r_qp);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_v1    <= 1'b0;
      r_addr1 <= '0;
    end else begin
      r_v1 <= w_rd;
      if (w_rd) begin
        r_addr1 <= addr_i;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Optional output register stage
  // --------------------------------------------------------------------------
  if (OUT_REGS != 0) begin : g_out_reg
    logic                  r_v2;
    logic [DATA_WIDTH-1:0] r_d2;
    logic [NB-1:0]         r_be2;
    logic [AW-1:0]         r_addr2;

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_v2    <= 1'b0;
        r_d2    <= '0;
        r_be2   <= '0;
        r_addr2 <= '0;
      end else begin
        r_v2  <= r_v1;
        r_be2 <= w_perr;
        if (r_v1) begin
          r_d2    <= w_q;
          r_addr2 <= r_addr1;
        end
      end
    end

    assign w_bv    = r_v2;
    assign w_bd    = r_d2;
    assign w_bbe   = r_be2;
    assign w_baddr = r_addr2;
  end else begin : g_out_comb
    assign w_bv    = r_v1;
    assign w_bd    = w_q;
    assign w_bbe   = w_perr;
    assign w_baddr = r_addr1;
  end

  assign rvalid_o  = w_bv;
  assign rdata_o   = w_bd;
  assign rerr_be_o = w_bbe;
  assign rerr_o    = |w_bbe;

  // --------------------------------------------------------------------------
  // Error log. An error beat takes priority over a simultaneous clear and
  // then counts as the first error of the new epoch.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_err_sticky <= 1'b0;
      r_err_addr   <= '0;
      r_err_cnt    <= '0;
    end else if (w_bv & rerr_o) begin
      r_err_sticky <= 1'b1;
      if (err_clr_i) begin
        r_err_cnt  <= ERR_CNT_WIDTH'(1);
        r_err_addr <= w_baddr;
      end else begin
        if (~&r_err_cnt) begin
          r_err_cnt <= r_err_cnt + ERR_CNT_WIDTH'(1);
        end
        if (!r_err_sticky) begin
          r_err_addr <= w_baddr;
        end
      end
    end else if (err_clr_i) begin
      r_err_sticky <= 1'b0;
      r_err_addr   <= '0;
      r_err_cnt    <= '0;
    end
  end

  assign err_sticky_o = r_err_sticky;
  assign err_addr_o   = r_err_addr;
  assign err_cnt_o    = r_err_cnt;

endmodule
`default_nettype wire

// File: doc/sram_ecc_par.md
# sram_ecc_par

Parity-protected single-port SRAM that succeeds the original single-parity FPGA SRAM wrapper. It generalises width, depth and read latency, and stores one even-parity bit per byte lane so partial byte-enable writes stay consistent. It checks parity on every read and reports errors per byte with each read beat. It also keeps a sticky error log (first failing address plus a saturating count) and runs a zero-initialisation sweep after reset. It sits between cache/scratchpad controllers and the inferred memory array.

## Interface
- DATA_WIDTH, 64, data bits per word (any value ≥ 1).
- NUM_WORDS, 1024, word count (≥ 2); AW = $clog2(NUM_WORDS).
- OUT_REGS, 0, 0: read latency 1 cycle; 1: extra output register, read latency 2 cycles.
- ERR_CNT_WIDTH, 8, width of the saturating error counter.
- INIT_ON_RESET, 1, 1: zero-fill sweep after reset; 0: ready immediately after reset.
- NB = (DATA_WIDTH+7)/8 byte lanes (derived). The last lane may be partial; its parity covers only the bits that exist.
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- req_i  in  1  access request.
- gnt_o  out  1  request accepted this cycle (= init done, not in reset).
- we_i  in  1  1 write, 0 read.
- addr_i  in  AW  word address.
- wdata_i  in  DATA_WIDTH  write data.
- be_i  in  NB  byte enables (writes only).
- inj_i  in  NB  error injection: invert the stored parity bit of the enabled lanes on this write.
- rdata_o  out  DATA_WIDTH  read data; holds the last value between reads.
- rvalid_o  out  1  rdata_o/rerr qualified, single-cycle pulse.
- rerr_o  out  1  any parity mismatch on this read beat.
- rerr_be_o  out  NB  per-lane mismatch.
- err_sticky_o  out  1  at least one error since the last clear.
- err_addr_o  out  AW  address of the first error since the last clear.
- err_cnt_o  out  ERR_CNT_WIDTH  errored read beats, saturating.
- err_clr_i  in  1  clear sticky, address and count.
- init_done_o  out  1  init sweep finished.

## Operation
- Storage:
  - Data array: NUM_WORDS × DATA_WIDTH.
  - Parity array: NUM_WORDS × NB flops, not reset.
- FSM has two states, INIT and READY.
  - Reset → INIT if INIT_ON_RESET=1, else READY.
  - INIT: each cycle writes word init_ptr with data 0 and parity 0 on all lanes, then increments init_ptr (reset value 0).
  - INIT → READY after writing word NUM_WORDS-1. The sweep takes exactly NUM_WORDS cycles.
  - gnt_o = 0 and init_done_o = 0 throughout INIT; requests are ignored, not queued.
- Accept = req_i & gnt_o.
- Write accept: for each lane b with be_i[b]=1:
  - data lane b ← wdata_i lane b;
  - par[b] ← ^(lane b) ^ inj_i[b].
  - Lanes with be_i[b]=0 are untouched, data and parity alike. No read beat is produced.
- Read accept:
  - Read word and parity at the edge.
  - Check: rerr_be_o[b] = ^(data lane b) ^ par[b]; rerr_o = |rerr_be_o.
  - Data is always delivered, including on error; there is no correction.
- Error log, updated on a beat with rvalid_o & rerr_o:
  - count += 1, saturating at all-ones;
  - err_sticky_o ← 1;
  - err_addr_o ← beat address, only if sticky was 0 before this beat.
- err_clr_i alone clears count, sticky and addr to 0.
- err_clr_i together with an error beat in the same cycle: the error wins. count = 1, sticky = 1, addr = beat address.
- Reset mid-INIT restarts the sweep at word 0. Reset with a read in flight drops the beat (no rvalid_o).

## Timing
- Reset values:
  - gnt_o 0, rvalid_o 0, rerr_o 0, rerr_be_o 0;
  - rdata_o 0;
  - err_sticky_o 0, err_addr_o 0, err_cnt_o 0;
  - init_done_o = !INIT_ON_RESET.
- When INIT_ON_RESET=1, gnt_o is first 1 NUM_WORDS cycles after the cycle rst_i is deasserted. When INIT_ON_RESET=0, gnt_o is 1 in the first cycle after deassertion.
- Read accepted at edge N:
  - OUT_REGS=0: rvalid_o/rdata_o/rerr* valid in cycle N+1.
  - OUT_REGS=1: valid in cycle N+2.
- Fully pipelined: one accept per cycle, back-to-back reads give back-to-back beats.
- A read after a write to the same address in the next cycle returns the new data.
- Error log outputs update one cycle after the errored beat. err_clr_i takes effect at the next edge.

## Test plan
- Init sweep: NUM_WORDS=16, INIT_ON_RESET=1. Deassert reset → gnt_o rises after exactly 16 cycles. Reading all 16 words returns 0 with rerr_o=0.
- Round trip: write 0xDEADBEEF_01234567 to address 5 with be=0xFF, then read → rdata 0xDEADBEEF_01234567, rerr_o=0, rvalid_o at N+1 (OUT_REGS=0) and at N+2 (OUT_REGS=1).
- Partial write: write 0xFF..FF, then write 0 with be=0x01 → read returns 0xFFFF_FFFF_FFFF_FF00 and no error.
- Injection: write addr 3 with inj_i=0x04, read addr 3 → rerr_be_o=0x04, rerr_o=1, err_addr_o=3, err_cnt_o=1. A second error at addr 7 gives err_addr_o=3, count=2.
- Saturation and clear: ERR_CNT_WIDTH=2, five errored reads → count=3. err_clr_i in the same cycle as an error beat → count=1, sticky=1.
- Reset mid-INIT and mid-read: assert rst_i at init_ptr=9 → the sweep restarts at 0 and takes the full 16 cycles. Reset during a pending read → no rvalid_o pulse.
